// File: rtl/cl_serial_driver.sv
`default_nettype none
// ============================================================================
// cl_serial_driver : bit-serial initiator for a shared 1-bit logic cell
// Rev 1.0
// ============================================================================
module cl_serial_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             cell_a,
  output logic             cell_b,
  output logic [1:0]       cell_s,
  input  logic             cell_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [1:0]       op_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] next_result;

  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);
  assign cell_a = busy & a_sh[0];
  assign cell_b = busy & b_sh[0];
  assign cell_s = busy ? op_reg : 2'b00;

  // The cell's bit enters at the MSB so the LSB pair lands in result[0].
  assign next_result = {cell_out, result[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      op_reg <= 2'b00;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            op_reg <= op;
            cnt    <= '0;
            result <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          result <= next_result;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Flag computed on the final word so it is valid alongside done.
            zero  <= (next_result == '0);
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cl_serial_driver.sv
`default_nettype none
// ============================================================================
// tb_cl_serial_driver : randomized scoreboard bench for cl_serial_driver
// Rev 1.0
// ============================================================================
module tb_cl_serial_driver;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0]   op = 2'b00;
  logic         cell_a, cell_b, cell_out, busy, done, zero;
  logic [1:0]   cell_s;
  logic [W-1:0] result;

  logic          start4 = 1'b0;
  logic [W4-1:0] a4 = '0, b4 = '0;
  logic [1:0]    op4 = 2'b00;
  logic          cell_a4, cell_b4, cell_out4, busy4, done4, zero4;
  logic [1:0]    cell_s4;
  logic [W4-1:0] result4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model of the shared 1-bit logic cell.
  function automatic logic cell_fn(input logic x, input logic y, input logic [1:0] s);
    case (s)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [1:0] s);
    case (s)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  assign cell_out  = cell_fn(cell_a, cell_b, cell_s);
  assign cell_out4 = cell_fn(cell_a4, cell_b4, cell_s4);

  cl_serial_driver #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .op(op),
    .cell_a(cell_a), .cell_b(cell_b), .cell_s(cell_s), .cell_out(cell_out),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  cl_serial_driver #(.WIDTH(W4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .op(op4),
    .cell_a(cell_a4), .cell_b(cell_b4), .cell_s(cell_s4), .cell_out(cell_out4),
    .busy(busy4), .done(done4), .result(result4), .zero(zero4)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] res;
    int           acc;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] last_res = '0;
  logic         last_zero = 1'b0;

  // Monitor: every cycle, derive the expected interface from the front entry.
  int           k;
  logic         e_busy, e_done, e_ca, e_cb, chk_res, e_zero;
  logic [1:0]   e_cs;
  logic [W-1:0] e_res;
  always @(negedge clk) begin
    if (!reset) begin
      e_busy = 1'b0; e_done = 1'b0; e_ca = 1'b0; e_cb = 1'b0; e_cs = 2'b00;
      chk_res = 1'b1; e_res = last_res; e_zero = last_zero;
      if (q.size() > 0) begin
        k = cyc - q[0].acc;
        if (k < W) begin
          e_busy = 1'b1;
          e_ca   = q[0].a[k];
          e_cb   = q[0].b[k];
          e_cs   = q[0].op;
          chk_res = (k == 0);
          e_res  = '0;
        end else begin
          e_done = 1'b1;
          e_res  = q[0].res;
          e_zero = (q[0].res == '0);
        end
      end
      checks++;
      if ({busy, done, cell_a, cell_b, cell_s} !== {e_busy, e_done, e_ca, e_cb, e_cs}) begin
        errors++;
        $display("FAIL ctl cyc=%0d busy/done/ca/cb/cs got %b%b%b%b%b exp %b%b%b%b%b",
                 cyc, busy, done, cell_a, cell_b, cell_s, e_busy, e_done, e_ca, e_cb, e_cs);
      end
      if (chk_res) begin
        checks++;
        if ({result, zero} !== {e_res, e_zero}) begin
          errors++;
          $display("FAIL result cyc=%0d got %h zero=%b exp %h zero=%b",
                   cyc, result, zero, e_res, e_zero);
        end
      end
      if (e_done) begin
        last_res  = e_res;
        last_zero = e_zero;
        void'(q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [1:0] opi, input int abort_at);
    exp_t e;
    a = ai; b = bi; op = opi; start = 1'b1;
    @(posedge clk); #1;
    e.a = ai; e.b = bi; e.op = opi; e.res = ref_op(ai, bi, opi); e.acc = cyc;
    q.push_back(e);
    for (int i = 0; i < W; i++) begin
      if (i + 1 == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        q.delete();
        last_res = '0; last_zero = 1'b0;
        return;
      end
      // Scramble inputs and hold start mid-run: neither may disturb the op.
      a = W'($urandom); b = W'($urandom); op = 2'($urandom); start = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b1;               // DONE cycle: must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    repeat ($urandom_range(2, 0)) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Narrow instance: XOR 9 ^ 5 = C, done in cycle 5.
    a4 = 4'h9; b4 = 4'h5; op4 = 2'b10; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != W4 + 1 || result4 !== 4'hC || zero4 !== 1'b0) begin
      errors++;
      $display("FAIL w4_xor got cycle=%0d result=%h zero=%b exp cycle=5 result=c zero=0",
               n, result4, zero4);
    end

    run_op(8'hF0, 8'h3C, 2'b00, 0);
    run_op(8'hA5, 8'h00, 2'b11, 0);
    run_op(8'h0F, 8'hF0, 2'b01, 0);
    run_op(8'hC3, 8'hC3, 2'b10, 0);
    run_op(8'hFF, 8'h01, 2'b00, 0);
    run_op(8'h5A, 8'h77, 2'b01, 4);
    run_op(8'h3C, 8'h0F, 2'b00, 0);
    for (int t = 0; t < 40; t++)
      run_op(W'($urandom), W'($urandom), 2'($urandom), 0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
